// File: rtl/sr_cmd_debounce_if.sv
// Button-to-SR-command bundle: raw button lines in, set/reset command pulses,
// debounced levels and the conflict flag out.
interface sr_cmd_debounce_if;
    logic set_btn;
    logic rst_btn;
    logic s_out;
    logic r_out;
    logic set_level;
    logic rst_level;
    logic conflict;

    // Driver of the raw buttons, consumer of the commands.
    modport master (
        output set_btn,
        output rst_btn,
        input  s_out,
        input  r_out,
        input  set_level,
        input  rst_level,
        input  conflict
    );

    // The debounce/arbiter block itself.
    modport slave (
        input  set_btn,
        input  rst_btn,
        output s_out,
        output r_out,
        output set_level,
        output rst_level,
        output conflict
    );
endinterface

// File: rtl/sr_cmd_debounce.sv
// Set/reset push-button front end for the SR flip-flop: synchronise each raw
// button, debounce it with a per-channel FSM, detect the rising edge of the
// debounced level and arbitrate so S and R are never commanded together.
module sr_cmd_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          R_PRIORITY      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    sr_cmd_debounce_if.slave io
);
    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES);
    localparam int unsigned   CH_S     = 0;
    localparam int unsigned   CH_R     = 1;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_CONFIRM_HIGH,
        ST_HIGH,
        ST_CONFIRM_LOW
    } db_state_e;

    logic [1:0]             btn;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [1:0]             sync_x;

    db_state_e              state_q [2];
    db_state_e              state_d [2];
    logic [CW-1:0]          cnt_q   [2];
    logic [CW-1:0]          cnt_d   [2];

    logic [1:0]             level_q;
    logic [1:0]             level_d;
    logic [1:0]             level_dly_q;
    logic [1:0]             rise;

    logic                   s_q;
    logic                   s_d;
    logic                   r_q;
    logic                   r_d;
    logic                   conflict_q;
    logic                   conflict_d;

    assign btn[CH_S] = io.set_btn;
    assign btn[CH_R] = io.rst_btn;

    // Synchroniser chains: shift the raw button in at bit 0, use the top bit.
    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            if (rst) begin
                sync_q[ch] <= '0;
            end else if (SYNC_STAGES > 1) begin
                sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], btn[ch]};
            end else begin
                sync_q[ch] <= {SYNC_STAGES{btn[ch]}};
            end
        end
    end

    // Synchronised view of each button.
    always_comb begin
        sync_x = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            sync_x[ch] = sync_q[ch][SYNC_STAGES-1];
        end
    end

    // Debounce FSM state, confirm counter and registered levels.
    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            if (rst) begin
                state_q[ch] <= ST_LOW;
                cnt_q[ch]   <= '0;
            end else begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
        if (rst) begin
            level_q     <= '0;
            level_dly_q <= '0;
        end else begin
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    // Debounce next state: a level flips only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample aborts the confirm.
    always_comb begin
        logic [CW-1:0] cnt_inc;
        cnt_inc = '0;
        level_d = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            cnt_inc     = cnt_q[ch] + 1'b1;
            unique case (state_q[ch])
                ST_LOW: begin
                    if (sync_x[ch]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d[ch] = ST_HIGH;
                            cnt_d[ch]   = '0;
                        end else begin
                            state_d[ch] = ST_CONFIRM_HIGH;
                            cnt_d[ch]   = CW'(1);
                        end
                    end
                end
                ST_CONFIRM_HIGH: begin
                    if (!sync_x[ch]) begin
                        state_d[ch] = ST_LOW;
                        cnt_d[ch]   = '0;
                    end else if (cnt_inc == DEB_LAST) begin
                        state_d[ch] = ST_HIGH;
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch]   = cnt_inc;
                    end
                end
                ST_HIGH: begin
                    if (!sync_x[ch]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d[ch] = ST_LOW;
                            cnt_d[ch]   = '0;
                        end else begin
                            state_d[ch] = ST_CONFIRM_LOW;
                            cnt_d[ch]   = CW'(1);
                        end
                    end
                end
                ST_CONFIRM_LOW: begin
                    if (sync_x[ch]) begin
                        state_d[ch] = ST_HIGH;
                        cnt_d[ch]   = '0;
                    end else if (cnt_inc == DEB_LAST) begin
                        state_d[ch] = ST_LOW;
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch]   = cnt_inc;
                    end
                end
                default: begin
                    state_d[ch] = ST_LOW;
                    cnt_d[ch]   = '0;
                end
            endcase
            level_d[ch] = (state_d[ch] == ST_HIGH) || (state_d[ch] == ST_CONFIRM_LOW);
        end
    end

    // A held button gives one rising edge; it re-arms only once the level drops.
    assign rise = level_q & ~level_dly_q;

    // Arbiter: on a same-cycle collision only the priority channel fires.
    always_comb begin
        s_d        = rise[CH_S] & ~(rise[CH_R] &  R_PRIORITY);
        r_d        = rise[CH_R] & ~(rise[CH_S] & ~R_PRIORITY);
        conflict_d = rise[CH_S] & rise[CH_R];
    end

    // Registered command pulses and conflict flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign io.s_out     = s_q;
    assign io.r_out     = r_q;
    assign io.set_level = level_q[CH_S];
    assign io.rst_level = level_q[CH_R];
    assign io.conflict  = conflict_q;
endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Bench for sr_cmd_debounce: one instance with reset priority, one with set
// priority, both fed the same buttons and checked every cycle against a
// run-length model, plus literal checks at hand-computed cycles.
module tb_sr_cmd_debounce;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sb  = 1'b0;
    logic rb  = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    int cnt_s1, cnt_r1, cnt_c1, cnt_s0, cnt_r0, cnt_c0, cnt_rl1;

    always #5 clk = ~clk;

    sr_cmd_debounce_if if1 ();
    sr_cmd_debounce_if if0 ();

    assign if1.set_btn = sb;
    assign if1.rst_btn = rb;
    assign if0.set_btn = sb;
    assign if0.rst_btn = rb;

    sr_cmd_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .R_PRIORITY     (1'b1)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .io (if1.slave)
    );

    sr_cmd_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .R_PRIORITY     (1'b0)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .io (if0.slave)
    );

    // Model: raw sample history, level per channel, and the length of the
    // current run of synchronised samples that disagree with the level.
    typedef struct {
        bit [7:0] sh_s;
        bit [7:0] sh_r;
        bit       lvl_s;
        bit       lvl_r;
        bit       prv_s;
        bit       prv_r;
        int       run_s;
        int       run_r;
        bit       s;
        bit       r;
        bit       c;
    } mdl_t;

    mdl_t m1 = '{default: 0};
    mdl_t m0 = '{default: 0};
    bit   started = 1'b0;

    function automatic mdl_t mstep(mdl_t m, bit rst_v, bit sbv, bit rbv, bit rp);
        mdl_t n;
        bit   rs;
        bit   rr;
        n = m;
        if (rst_v) begin
            n = '{default: 0};
            return n;
        end
        rs = m.lvl_s && !m.prv_s;
        rr = m.lvl_r && !m.prv_r;
        n.s = rs && !(rr && rp);
        n.r = rr && !(rs && !rp);
        n.c = rs && rr;
        n.prv_s = m.lvl_s;
        n.prv_r = m.lvl_r;
        if (m.sh_s[SYNC-1] != m.lvl_s) begin
            n.run_s = m.run_s + 1;
            if (n.run_s == DEB) begin
                n.lvl_s = !m.lvl_s;
                n.run_s = 0;
            end
        end else begin
            n.run_s = 0;
        end
        if (m.sh_r[SYNC-1] != m.lvl_r) begin
            n.run_r = m.run_r + 1;
            if (n.run_r == DEB) begin
                n.lvl_r = !m.lvl_r;
                n.run_r = 0;
            end
        end else begin
            n.run_r = 0;
        end
        n.sh_s = {m.sh_s[6:0], sbv};
        n.sh_r = {m.sh_r[6:0], rbv};
        return n;
    endfunction

    always @(posedge clk) begin
        m1      <= mstep(m1, rst, sb, rb, 1'b1);
        m0      <= mstep(m0, rst, sb, rb, 1'b0);
        started <= 1'b1;
    end

    task automatic chk(string nm, logic s, logic r, logic sl, logic rl, logic c, mdl_t m);
        vectors++;
        if ({s, r, sl, rl, c} !== {m.s, m.r, m.lvl_s, m.lvl_r, m.c}) begin
            miscompares++;
            $display("FAIL %s t=%0t: s/r/slvl/rlvl/conf got %b%b%b%b%b want %b%b%b%b%b",
                     nm, $time, s, r, sl, rl, c, m.s, m.r, m.lvl_s, m.lvl_r, m.c);
        end
        vectors++;
        if ((s & r) !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_both t=%0t: s_out&r_out got %b want 0", nm, $time, s & r);
        end
    endtask

    // Compare process: both instances against the model on every cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("rp1", if1.s_out, if1.r_out, if1.set_level, if1.rst_level, if1.conflict, m1);
            chk("rp0", if0.s_out, if0.r_out, if0.set_level, if0.rst_level, if0.conflict, m0);
        end
    end

    task automatic pin(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic clr();
        cnt_s1 = 0; cnt_r1 = 0; cnt_c1 = 0;
        cnt_s0 = 0; cnt_r0 = 0; cnt_c0 = 0;
        cnt_rl1 = 0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            cnt_s1  += int'(if1.s_out);
            cnt_r1  += int'(if1.r_out);
            cnt_c1  += int'(if1.conflict);
            cnt_s0  += int'(if0.s_out);
            cnt_r0  += int'(if0.r_out);
            cnt_c0  += int'(if0.conflict);
            cnt_rl1 += int'(if1.rst_level);
        end
    endtask

    initial begin
        clr();
        // Reset held 3 cycles with both buttons high.
        sb = 1'b1; rb = 1'b1; rst = 1'b1;
        idle(3);
        pin("rst_s_out", cnt_s1 + cnt_s0, 0);
        pin("rst_r_out", cnt_r1 + cnt_r0, 0);
        pin("rst_conf", cnt_c1 + cnt_c0, 0);
        rst = 1'b0;
        idle(6);
        pin("rel_slvl_e6", int'(if1.set_level), 1);
        pin("rel_rlvl_e6", int'(if1.rst_level), 1);
        pin("rel_r_e6", int'(if1.r_out), 0);
        idle(1);
        pin("rel_rp1_r_e7", int'(if1.r_out), 1);
        pin("rel_rp1_c_e7", int'(if1.conflict), 1);
        pin("rel_rp1_s_e7", int'(if1.s_out), 0);
        pin("rel_rp0_s_e7", int'(if0.s_out), 1);
        pin("rel_rp0_r_e7", int'(if0.r_out), 0);
        pin("model_rp1_r_e7", int'(m1.r), 1);
        idle(1);
        pin("rel_rp1_r_e8", int'(if1.r_out), 0);
        pin("rel_rp1_c_e8", int'(if1.conflict), 0);
        sb = 1'b0; rb = 1'b0;
        idle(12);

        // Clean press held 20 cycles.
        clr();
        sb = 1'b1;
        idle(5);
        pin("press_slvl_e5", int'(if1.set_level), 0);
        idle(1);
        pin("press_slvl_e6", int'(if1.set_level), 1);
        pin("press_s_e6", int'(if1.s_out), 0);
        idle(1);
        pin("press_s_e7", int'(if1.s_out), 1);
        pin("model_s_e7", int'(m1.s), 1);
        idle(1);
        pin("press_s_e8", int'(if1.s_out), 0);
        idle(12);
        pin("press_s_count", cnt_s1, 1);
        sb = 1'b0;
        idle(6);
        pin("release_slvl", int'(if1.set_level), 0);
        idle(4);
        pin("release_no_s", cnt_s1, 1);

        // 3-cycle glitch, then a 10-cycle press.
        clr();
        rb = 1'b1;
        idle(3);
        rb = 1'b0;
        idle(12);
        pin("glitch_rlvl", cnt_rl1, 0);
        pin("glitch_r", cnt_r1 + cnt_r0, 0);
        clr();
        rb = 1'b1;
        idle(10);
        rb = 1'b0;
        idle(10);
        pin("after_glitch_r1", cnt_r1, 1);
        pin("after_glitch_r0", cnt_r0, 1);

        // Simultaneous press.
        clr();
        sb = 1'b1; rb = 1'b1;
        idle(7);
        pin("sim_rp0_s", int'(if0.s_out), 1);
        pin("sim_rp0_c", int'(if0.conflict), 1);
        pin("sim_rp0_r", int'(if0.r_out), 0);
        pin("sim_rp1_r", int'(if1.r_out), 1);
        idle(8);
        pin("sim_rp0_scnt", cnt_s0, 1);
        pin("sim_rp0_rcnt", cnt_r0, 0);
        pin("sim_rp0_ccnt", cnt_c0, 1);
        sb = 1'b0; rb = 1'b0;
        idle(10);

        // Staggered press: reset button one cycle after set button.
        clr();
        sb = 1'b1;
        idle(1);
        rb = 1'b1;
        idle(6);
        pin("stag_s_e7", int'(if1.s_out), 1);
        pin("stag_r_e7", int'(if1.r_out), 0);
        idle(1);
        pin("stag_s_e8", int'(if1.s_out), 0);
        pin("stag_r_e8", int'(if1.r_out), 1);
        idle(10);
        pin("stag_c1", cnt_c1, 0);
        pin("stag_c0", cnt_c0, 0);
        pin("stag_scnt", cnt_s1, 1);
        pin("stag_rcnt", cnt_r1, 1);
        sb = 1'b0; rb = 1'b0;
        idle(10);

        // Reset while set channel is confirming (count 2).
        clr();
        sb = 1'b1;
        idle(4);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        pin("midrst_no_s", cnt_s1, 0);
        clr();
        idle(6);
        pin("midrst_s_e6", int'(if1.s_out), 0);
        idle(1);
        pin("midrst_s_e7", int'(if1.s_out), 1);
        idle(8);
        pin("midrst_scnt", cnt_s1, 1);
        sb = 1'b0;
        idle(10);

        // Held reset button does not block a later set edge.
        clr();
        rb = 1'b1;
        idle(12);
        sb = 1'b1;
        idle(7);
        pin("indep_s_e7", int'(if1.s_out), 1);
        pin("indep_r_e7", int'(if1.r_out), 0);
        idle(4);
        pin("indep_rcnt", cnt_r1, 1);
        pin("indep_scnt", cnt_s1, 1);
        sb = 1'b0; rb = 1'b0;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sr_cmd_debounce.md
# sr_cmd_debounce

Front-end stage that drives the S and R inputs of the team's SR flip-flop from two raw, asynchronous push-button lines. Each line is synchronized, debounced by a per-channel state machine, and rising-edge detected. The result is single-cycle set/reset command pulses. An arbiter guarantees that `s_out` and `r_out` are never high in the same cycle, so the downstream flop never sees the invalid 11 code.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchronizer flops per input; minimum 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized input must differ from the debounced level before the level flips; minimum 1.
- `R_PRIORITY`, default 1: 1 means reset wins on a simultaneous edge; 0 means set wins.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `set_btn`, in, 1: raw asynchronous set request.
- `rst_btn`, in, 1: raw asynchronous reset request.
- `s_out`, out, 1: one-cycle set command to the SR flop S input.
- `r_out`, out, 1: one-cycle reset command to the SR flop R input.
- `set_level`, out, 1: debounced level of `set_btn`.
- `rst_level`, out, 1: debounced level of `rst_btn`.
- `conflict`, out, 1: one-cycle flag; both edges arrived in the same cycle and one was dropped.

## Operation
- **Synchronizer:** each raw input passes through a `SYNC_STAGES`-deep flop chain, giving `sync_x`.
- **Debounce FSM**, one per channel. States: LOW, CONFIRM_HIGH, HIGH, CONFIRM_LOW. Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - LOW: if `sync_x`=1, go to CONFIRM_HIGH with count=1. If `DEBOUNCE_CYCLES`=1, go directly to HIGH.
  - CONFIRM_HIGH: if `sync_x`=0, return to LOW and clear the count. Otherwise increment; when the count reaches `DEBOUNCE_CYCLES`, go to HIGH.
  - HIGH and CONFIRM_LOW behave symmetrically, with the polarity inverted.
  - The level is 1 in states HIGH and CONFIRM_LOW, and 0 otherwise. The level output is registered.
- **Edge detect:** `rise_x` = level & ~level_d. Falling edges produce no command.
- **Arbiter, registered outputs:**
  - `rise_s` only: `s_out`=1 next cycle.
  - `rise_r` only: `r_out`=1 next cycle.
  - Both in the same cycle: only the priority channel pulses (`r_out` if `R_PRIORITY`=1, else `s_out`), and `conflict`=1 in the same cycle as that pulse.
  - Invariant: `s_out & r_out` is never 1.
- **Held-button rule:** a held button produces exactly one pulse. It re-arms only after its debounced level returns to 0.
- **Independence:** the channels are independent. A held reset does not block a later set edge; the downstream flop resolves the order.

## Timing
- **Reset values:** all synchronizer flops 0; both FSMs in LOW with count 0; `set_level`=`rst_level`=0; `s_out`=`r_out`=`conflict`=0.
- **Reset is synchronous:** an in-flight confirm is discarded at the first `rst` edge, and any output pulse due on the next cycle is suppressed.
- **Button high at reset release:** treated as a fresh rising input; one pulse follows after the full latency.
- **Latency:** raw input stable high before edge 0 gives:
  - `sync_x`=1 after edge `SYNC_STAGES`;
  - level=1 after edge `SYNC_STAGES+DEBOUNCE_CYCLES`;
  - command pulse high after edge `SYNC_STAGES+DEBOUNCE_CYCLES+1`, for exactly one cycle.
  - With defaults, the pulse is high after edge 7 and low after edge 8.
- **Release:** level=0 after `SYNC_STAGES+DEBOUNCE_CYCLES` edges, with no pulse.
- **Glitch rejection:** a synchronized glitch of fewer than `DEBOUNCE_CYCLES` cycles returns the FSM to its stable state with the count cleared. A later valid press still needs the full `DEBOUNCE_CYCLES`.
- **Simultaneous edges:** only count as simultaneous when both `rise_x` fall in the same cycle. Edges one cycle apart produce two separate pulses on consecutive cycles, with `conflict`=0.
- **Pulse spacing:** pulse width is always exactly 1 cycle. Minimum spacing between two pulses on one channel is `2*DEBOUNCE_CYCLES` cycles.

## Test plan
- **Reset:** hold `rst` 3 cycles with both buttons high. Required: all outputs 0 during reset. After release, with defaults, `s_out` pulses after edge 7 and `r_out` pulses in the same cycle? No: `r_out` pulses and `conflict`=1 in the same cycle, `s_out`=0 (`R_PRIORITY`=1).
- **Clean press, defaults:** `set_btn` 0→1 and held 20 cycles. Required: `set_level`=1 after edge 6; `s_out`=1 for exactly the cycle after edge 7; no further pulses while held.
- **Glitch:** `rst_btn` high for 3 cycles, then low. Required: `rst_level` stays 0 and `r_out` never asserts. A subsequent 10-cycle press gives exactly one `r_out` pulse.
- **Simultaneous press, `R_PRIORITY`=0:** both buttons rise together. Required: one `s_out` pulse, `conflict`=1 in that cycle, `r_out` stays 0.
- **Staggered press:** `rst_btn` rises one cycle after `set_btn`. Required: `s_out` pulse then `r_out` pulse on consecutive cycles, `conflict`=0, never both high.
- **Reset mid-confirm:** assert `rst` while `set_btn` is in CONFIRM_HIGH (count 2). Required: no `s_out` pulse. After release, with the button still high, one pulse after the full 7-edge latency.
